vend_ctrl: RTL and testbench

- Parametrised multi-item vending controller; successor to the single-price seller.
- Accepts coins into a credit register and takes an item selection checked against per-item price and stock.
- After a sale it dispenses change as a sequence of coins, largest first, one per cycle.
- Sits between the coin/keypad input logic and the dispenser/display drivers.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_if.sv | 37 +++
 rtl/vend_change_gen.sv | 67 ++++++
 rtl/vend_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vend_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller: FSM encodings,
// change denominations and the price-list slicing helper.
package vend_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    typedef logic [2:0] coin_t;

    localparam coin_t COIN_5 = 3'd5;
    localparam coin_t COIN_2 = 3'd2;
    localparam coin_t COIN_1 = 3'd1;

    // Widest price list the helper accepts; callers zero-extend into it.
    localparam int PRICE_BUS_MAX = 256;

    function automatic logic [31:0] price_slice(
        input logic [PRICE_BUS_MAX-1:0] list,
        input int unsigned              idx,
        input int unsigned              width
    );
        logic [PRICE_BUS_MAX-1:0] shifted;
        logic [31:0]              mask;
        shifted = list >> (idx * width);
        mask    = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/vend_if.sv
// Bundle between the coin/keypad front end (master) and the vending
// controller (slave); the controller's outputs feed the dispenser/display.
interface vend_if #(
    parameter int CREDIT_W = 5,
    parameter int N_ITEMS  = 4,
    parameter int SEL_W    = 2
);
    logic                coin_valid;
    logic [2:0]          coin;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel;
    logic                cancel;
    logic                restock;

    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                coin_reject;
    logic                sel_err;
    logic                vend_valid;
    logic [SEL_W-1:0]    vend_item;
    logic                change_valid;
    logic [2:0]          change_coin;
    logic [N_ITEMS-1:0]  sold_out;

    modport master (
        output coin_valid, coin, sel_valid, sel, cancel, restock,
        input  credit, busy, coin_reject, sel_err, vend_valid, vend_item,
               change_valid, change_coin, sold_out
    );

    modport slave (
        input  coin_valid, coin, sel_valid, sel, cancel, restock,
        output credit, busy, coin_reject, sel_err, vend_valid, vend_item,
               change_valid, change_coin, sold_out
    );

endinterface

// File: rtl/vend_change_gen.sv
// Change dispenser: on load it starts paying out the loaded value, one coin
// per cycle, largest denomination first; done marks the last coin's cycle.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         change_valid,
    output logic [2:0]   change_coin,
    output logic         done
);

    logic [W-1:0] rem_q, rem_d;
    logic         change_valid_q, change_valid_d;
    coin_t        change_coin_q, change_coin_d;

    logic [W-1:0] src;
    logic         active;
    coin_t        coin_pick;

    always_comb begin
        // NOTE: every _d gets a default before any branch so none can infer a latch.
        rem_d          = rem_q;
        change_valid_d = 1'b0;
        change_coin_d  = '0;

        // A load pays its first coin on the same edge it is captured.
        src    = load ? load_val : rem_q;
        active = load || (rem_q != '0);

        if (src >= W'(COIN_5)) begin
            coin_pick = COIN_5;
        end else if (src >= W'(COIN_2)) begin
            coin_pick = COIN_2;
        end else begin
            coin_pick = COIN_1;
        end

        if (active) begin
            rem_d          = src - W'(coin_pick);
            change_valid_d = 1'b1;
            change_coin_d  = coin_pick;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rem_q          <= '0;
            change_valid_q <= 1'b0;
            change_coin_q  <= '0;
        end else begin
            rem_q          <= rem_d;
            change_valid_q <= change_valid_d;
            change_coin_q  <= change_coin_d;
        end
    end

    assign change_valid = change_valid_q;
    assign change_coin  = change_coin_q;
    assign done         = change_valid_q && (rem_q == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Multi-item vending controller: credit accumulation, priced/stocked item
// selection, one-cycle vend strobe and largest-first change payout.
module vend_ctrl #(
    parameter int                          CREDIT_W   = 5,
    parameter int                          N_ITEMS    = 4,
    parameter int                          SEL_W      = 2,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST = {5'd12, 5'd10, 5'd7, 5'd5},
    parameter int                          STOCK_W    = 3,
    parameter int                          STOCK_INIT = 2
) (
    input  logic clk,
    input  logic clr_n,
    vend_if.slave bus
);
    import vend_pkg::*;

    localparam logic [STOCK_W-1:0]       STOCK_INIT_V = STOCK_W'(STOCK_INIT);
    localparam logic [N_ITEMS-1:0]       SOLD_OUT_RST = (STOCK_INIT == 0) ? '1 : '0;
    localparam logic [PRICE_BUS_MAX-1:0] PRICE_BUS    = PRICE_BUS_MAX'(PRICE_LIST);

    logic [CREDIT_W-1:0] price_tab [N_ITEMS];

    for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_price
        localparam logic [31:0] P = price_slice(PRICE_BUS, gi, CREDIT_W);
        assign price_tab[gi] = P[CREDIT_W-1:0];
    end

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] vend_rem_q, vend_rem_d;
    logic [STOCK_W-1:0]  stock_q [N_ITEMS];
    logic [STOCK_W-1:0]  stock_d [N_ITEMS];
    logic                vend_valid_q, vend_valid_d;
    logic [SEL_W-1:0]    vend_item_q, vend_item_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_err_q, sel_err_d;
    logic                busy_q, busy_d;
    logic [N_ITEMS-1:0]  sold_out_q, sold_out_d;

    logic                chg_load;
    logic [CREDIT_W-1:0] chg_val;
    logic                chg_done;

    logic                coin_present;
    logic [CREDIT_W:0]   credit_sum;
    logic                sel_in_range;
    logic [STOCK_W-1:0]  sel_stock;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_accept;
    logic                sale;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_rem_d    = vend_rem_q;
        stock_d       = stock_q;
        vend_valid_d  = 1'b0;
        vend_item_d   = '0;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        chg_load      = 1'b0;
        chg_val       = vend_rem_q;

        coin_present = bus.coin_valid && (bus.coin != 3'd0);
        credit_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(bus.coin);

        sel_in_range = int'(bus.sel) < N_ITEMS;
        sel_stock    = '0;
        sel_price    = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (int'(bus.sel) == i) begin
                sel_stock = stock_q[i];
                sel_price = price_tab[i];
            end
        end
        sel_accept = sel_in_range && (sel_stock != '0) && (credit_q >= sel_price);
        sale       = (state_q == ST_IDLE) && !bus.cancel && bus.sel_valid && sel_accept;

        case (state_q)
            ST_IDLE: begin
                if (bus.cancel) begin
                    credit_d      = '0;
                    coin_reject_d = coin_present;
                    if (credit_q != '0) begin
                        chg_load = 1'b1;
                        chg_val  = credit_q;
                        state_d  = ST_CHANGE;
                    end
                end else if (sale) begin
                    vend_rem_d    = credit_q - sel_price;
                    credit_d      = '0;
                    vend_valid_d  = 1'b1;
                    vend_item_d   = bus.sel;
                    coin_reject_d = coin_present;
                    state_d       = ST_VEND;
                    for (int i = 0; i < N_ITEMS; i++) begin
                        if (int'(bus.sel) == i) stock_d[i] = stock_q[i] - 1'b1;
                    end
                end else begin
                    // A refused selection still lets a same-cycle coin through.
                    sel_err_d = bus.sel_valid;
                    if (coin_present) begin
                        if (credit_sum[CREDIT_W]) coin_reject_d = 1'b1;
                        else                      credit_d      = credit_sum[CREDIT_W-1:0];
                    end
                end

                if (bus.restock && !sale) begin
                    for (int i = 0; i < N_ITEMS; i++) stock_d[i] = STOCK_INIT_V;
                end
            end

            ST_VEND: begin
                coin_reject_d = coin_present;
                sel_err_d     = bus.sel_valid;
                if (vend_rem_q != '0) begin
                    chg_load = 1'b1;
                    state_d  = ST_CHANGE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_CHANGE: begin
                coin_reject_d = coin_present;
                sel_err_d     = bus.sel_valid;
                if (chg_done) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        for (int i = 0; i < N_ITEMS; i++) sold_out_d[i] = (stock_d[i] == '0);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            vend_rem_q    <= '0;
            vend_valid_q  <= 1'b0;
            vend_item_q   <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            sold_out_q    <= SOLD_OUT_RST;
            // NOTE: the stock array is a handful of counters, not a RAM, so it is reset like any flop.
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_INIT_V;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_rem_q    <= vend_rem_d;
            vend_valid_q  <= vend_valid_d;
            vend_item_q   <= vend_item_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
            busy_q        <= busy_d;
            sold_out_q    <= sold_out_d;
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
        end
    end

    vend_change_gen #(
        .W (CREDIT_W)
    ) u_change_gen (
        .clk          (clk),
        .clr_n        (clr_n),
        .load         (chg_load),
        .load_val     (chg_val),
        .change_valid (bus.change_valid),
        .change_coin  (bus.change_coin),
        .done         (chg_done)
    );

    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sel_err     = sel_err_q;
    assign bus.vend_valid  = vend_valid_q;
    assign bus.vend_item   = vend_item_q;
    assign bus.sold_out    = sold_out_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed table-driven bench for vend_ctrl with default prices {12,10,7,5}
// (item 0 = 5) and two units of stock per item.
module tb_vend_ctrl;

    localparam int CREDIT_W = 5;
    localparam int N_ITEMS  = 4;
    localparam int SEL_W    = 2;

    logic clk = 1'b0;
    logic clr_n;

    always #5 clk = ~clk;

    vend_if #(.CREDIT_W(CREDIT_W), .N_ITEMS(N_ITEMS), .SEL_W(SEL_W)) bus ();

    vend_ctrl #(
        .CREDIT_W   (CREDIT_W),
        .N_ITEMS    (N_ITEMS),
        .SEL_W      (SEL_W),
        .PRICE_LIST ({5'd12, 5'd10, 5'd7, 5'd5}),
        .STOCK_W    (3),
        .STOCK_INIT (2)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    typedef struct {
        logic       cv;
        logic [2:0] coin;
        logic       sv;
        logic [1:0] sel;
        logic       can;
        logic       rs;
        logic [4:0] credit;
        logic       busy;
        logic       crej;
        logic       serr;
        logic       vv;
        logic [1:0] vi;
        logic       chv;
        logic [2:0] chc;
        logic [3:0] so;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tbl[$];
    vec_t post_rst[$];

    function automatic vec_t mk(int cv, int coin, int sv, int sel, int can, int rs,
                                int credit, int busy, int crej, int serr, int vv, int vi,
                                int chv, int chc, int so);
        vec_t v;
        v.cv = 1'(cv);      v.coin = 3'(coin);  v.sv = 1'(sv);   v.sel = 2'(sel);
        v.can = 1'(can);    v.rs = 1'(rs);      v.credit = 5'(credit);
        v.busy = 1'(busy);  v.crej = 1'(crej);  v.serr = 1'(serr);
        v.vv = 1'(vv);      v.vi = 2'(vi);      v.chv = 1'(chv);
        v.chc = 3'(chc);    v.so = 4'(so);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx, input vec_t v);
        check({tag, ".credit"},       idx, 32'(bus.credit),       32'(v.credit));
        check({tag, ".busy"},         idx, 32'(bus.busy),         32'(v.busy));
        check({tag, ".coin_reject"},  idx, 32'(bus.coin_reject),  32'(v.crej));
        check({tag, ".sel_err"},      idx, 32'(bus.sel_err),      32'(v.serr));
        check({tag, ".vend_valid"},   idx, 32'(bus.vend_valid),   32'(v.vv));
        check({tag, ".vend_item"},    idx, 32'(bus.vend_item),    32'(v.vi));
        check({tag, ".change_valid"}, idx, 32'(bus.change_valid), 32'(v.chv));
        check({tag, ".change_coin"},  idx, 32'(bus.change_coin),  32'(v.chc));
        check({tag, ".sold_out"},     idx, 32'(bus.sold_out),     32'(v.so));
    endtask

    task automatic drive(input vec_t v);
        bus.coin_valid = v.cv;
        bus.coin       = v.coin;
        bus.sel_valid  = v.sv;
        bus.sel        = v.sel;
        bus.cancel     = v.can;
        bus.restock    = v.rs;
    endtask

    task automatic apply(input string tag, input int idx, input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check_outs(tag, idx, v);
    endtask

    initial begin
        vec_t zero;
        zero = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);

        //                cv co sv sl cn rs   cr bz cj se vv vi cv cc so
        // coins 2,2,1 then buy item 0 (price 5), exact credit
        tbl.push_back(mk(1, 2, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 7+7=14, buy item 3 (price 12), change 2
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,  14, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3, 0, 0,   0, 1, 0, 0, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        // credit 13, cancel -> 5,5,2,1; coin and sel during payout are refused
        tbl.push_back(mk(1, 6, 0, 0, 0, 0,   6, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,  13, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 1, 5, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 1, 5, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,   0, 1, 0, 1, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        // credit 28, coin 5 overflows, coin 3 lands exactly on 31
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,  14, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,  21, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,  28, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0,  28, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0,  31, 0, 0, 0, 0, 0, 0, 0, 0));
        // cancel 31 with a coin the same cycle: coin rejected, 5x6 + 1 paid out
        tbl.push_back(mk(1, 2, 0, 0, 1, 0,   0, 1, 1, 0, 0, 0, 1, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        // credit 4 vs item 1 (price 7): refused; refused sel + coin still credits
        tbl.push_back(mk(1, 4, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   4, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 0, 0,   7, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,   0, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        // two sales of item 2 (price 10) empty it; third refused; restock refills
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0,  12, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 2, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 4, 0, 0, 0, 0,  11, 0, 0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 1, 2, 0, 0,  11, 0, 0, 1, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  11, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        // zero-valued coin is ignored, not rejected
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));

        // after a mid-payout reset: idle, then one sale of item 2 must not empty it
        post_rst.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
        post_rst.push_back(mk(1, 7, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 0, 0, 0));
        post_rst.push_back(mk(1, 3, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0, 0, 0));
        post_rst.push_back(mk(0, 0, 1, 2, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 0));
        post_rst.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));

        clr_n = 1'b0;
        drive(zero);
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, zero);
        @(negedge clk);
        clr_n = 1'b1;

        foreach (tbl[i]) apply("tbl", i, tbl[i]);

        // 13-unit cancel, then pull clr_n low during the second change coin
        apply("rst_seq", 0, mk(1, 6, 0, 0, 0, 0,   6, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("rst_seq", 1, mk(1, 7, 0, 0, 0, 0,  13, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("rst_seq", 2, mk(0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 1, 5, 0));
        apply("rst_seq", 3, mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 5, 0));
        #2;
        clr_n = 1'b0;
        #1;
        check_outs("async_rst", 0, zero);
        @(posedge clk);
        #1;
        check_outs("rst_hold", 0, zero);
        @(negedge clk);
        clr_n = 1'b1;

        foreach (post_rst[i]) apply("post_rst", i, post_rst[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
